// File: rtl/axis_uart_tx_fifo.sv
// UART transmitter fed by an AXI-Stream slave through a synchronous FIFO.
// Runtime baud divisor, optional parity, 1/2 stop bits, frame/packet completion pulses.
module axis_uart_tx_fifo #(
  parameter int unsigned CLK_RATE   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned WORD_LEN   = 8,
  parameter string       PARITY     = "even",
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_LEN-1:0]           s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic [15:0]                   baud_div_in,
  input  logic                          baud_div_load,
  input  logic                          tx_enable,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          last_done
);

  localparam int unsigned     AddrW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     Div0      = 16'(CLK_RATE / BAUD);
  localparam logic [AddrW:0]  FullLevel = (AddrW + 1)'(FIFO_DEPTH);
  localparam bit              HasParity = (PARITY != "none");
  localparam bit              OddParity = (PARITY == "odd");

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage: {tlast, data}
  logic [WORD_LEN:0] mem [FIFO_DEPTH];
  logic [AddrW:0]    wr_ptr_q, rd_ptr_q;
  logic [WORD_LEN:0] head;
  logic              push, pop, full, empty;

  assign fifo_level    = wr_ptr_q - rd_ptr_q;
  assign full          = (fifo_level == FullLevel);
  assign empty         = (fifo_level == '0);
  assign s_axis_tready = !full;
  assign push          = s_axis_tvalid && !full;
  assign head          = mem[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AddrW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Serializer
  state_e              state_q, state_d;
  logic [15:0]         baud_cnt_q, baud_cnt_d;
  logic [15:0]         div_q, div_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [WORD_LEN-1:0] shreg_q, shreg_d;
  logic                par_q, par_d;
  logic                last_q, last_d;
  logic                tx_q, tx_d;
  logic                frame_done_q, frame_done_d;
  logic                last_done_q, last_done_d;
  logic                can_pop, bit_end;

  assign can_pop = !empty && tx_enable;
  assign bit_end = (baud_cnt_q == div_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = bit_end ? '0 : baud_cnt_q + 16'd1;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    last_d       = last_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    last_done_d  = 1'b0;
    pop          = 1'b0;
    div_d        = div_q;

    if (baud_div_load && state_q == StIdle) begin
      div_d = (baud_div_in < 16'd2) ? 16'd2 : baud_div_in;
    end

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        pop        = can_pop;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'(WORD_LEN - 1)) begin
            bit_cnt_d = '0;
            if (HasParity) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            frame_done_d = 1'b1;
            last_done_d  = last_q;
            // Chain straight into the next START when work is waiting
            pop          = can_pop;
            if (!can_pop) state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      state_d    = StStart;
      tx_d       = 1'b0;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shreg_d    = head[WORD_LEN-1:0];
      last_d     = head[WORD_LEN];
      par_d      = (^head[WORD_LEN-1:0]) ^ OddParity;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      baud_cnt_q   <= '0;
      div_q        <= Div0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      last_q       <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
      last_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      last_q       <= last_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
      last_done_q  <= last_done_d;
    end
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign last_done  = last_done_q;

endmodule
